// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and select-width helper for the stream mux
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: combinational rotating-priority picker, searching from last+1 cyclically
module mux_rr_pick
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // walk the ring backwards so the nearest requester after last wins
    for (int i = NCH; i >= 1; i--) begin
      if (req[(32'(last) + i) % NCH]) begin
        gnt_idx = SELW'((32'(last) + i) % NCH);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: registered N-to-1 valid/ready stream mux, fixed or round-robin select
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SELW-1:0]  last_ch, rr_idx, g;
  logic             rr_any, gv, slot_free, xfer;
  logic [WIDTH-1:0] word;
  mux_rr_pick #(.NCH(NCH)) u_pick (
    .req(in_valid),
    .last(last_ch),
    .gnt_idx(rr_idx),
    .gnt_any(rr_any)
  );
  assign slot_free = !out_valid || out_ready;
  assign g = (mode == MODE_RR) ? rr_idx : sel;
  assign gv = (mode == MODE_RR) ? rr_any : (32'(sel) < NCH);
  always_comb begin
    in_ready = '0;
    word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (g == SELW'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = slot_free && gv && !rst;
      end
    end
  end
  assign xfer = |(in_valid & in_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      last_ch <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= word;
      out_ch <= g;
      last_ch <= g;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: randomized + directed check of a 4-channel and a 3-channel mux against a behavioural model
module tb_mux_nto1_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        out_ready = 1'b1;
  logic [1:0]  sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = 4'hf;
  logic [3:0]  a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_valid;
  logic [2:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_valid;
  always #5 clk = ~clk;
  mux_nto1_stream #(.WIDTH(8), .NCH(4)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(out_ready)
  );
  mux_nto1_stream #(.WIDTH(8), .NCH(3)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(out_ready)
  );
  int checks = 0;
  int failures = 0;
  bit started = 0;
  int nch[2] = '{4, 3};
  int mv[2], mch[2], mlast[2];
  logic [7:0] md[2];
  logic [1:0] qch[$];
  logic [7:0] qd[$];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int grant(input int n, input logic m, input logic [1:0] s, input logic [3:0] v, input int last);
    if (!m) return (int'(s) < n) ? int'(s) : -1;
    for (int i = 1; i <= n; i++) if (v[(last + i) % n]) return (last + i) % n;
    return -1;
  endfunction
  function automatic int exp_ready(input int i);
    int gg;
    if (rst || !(mv[i] == 0 || out_ready)) return 0;
    gg = grant(nch[i], mode, sel, in_valid, mlast[i]);
    return (gg < 0) ? 0 : (1 << gg);
  endfunction
  always @(posedge clk) begin
    if (a_out_valid && out_ready && !rst) begin
      qch.push_back(a_out_ch);
      qd.push_back(a_out_data);
    end
    for (int i = 0; i < 2; i++) begin
      int gg;
      bit free;
      if (rst) begin
        mv[i] = 0; md[i] = 8'h00; mch[i] = 0; mlast[i] = nch[i] - 1;
      end else begin
        free = (mv[i] == 0) || out_ready;
        gg = grant(nch[i], mode, sel, in_valid, mlast[i]);
        if (free && gg >= 0 && in_valid[gg]) begin
          mv[i] = 1; md[i] = in_data[gg*8 +: 8]; mch[i] = gg; mlast[i] = gg;
        end else if (free) mv[i] = 0;
      end
    end
    started = 1;
  end
  always @(negedge clk) begin
    if (started) begin
      chk("a_in_ready", int'(a_in_ready), exp_ready(0));
      chk("a_out_valid", int'(a_out_valid), mv[0]);
      chk("a_out_data", int'(a_out_data), int'(md[0]));
      chk("a_out_ch", int'(a_out_ch), mch[0]);
      chk("b_in_ready", int'(b_in_ready), exp_ready(1));
      chk("b_out_valid", int'(b_out_valid), mv[1]);
      chk("b_out_data", int'(b_out_data), int'(md[1]));
      chk("b_out_ch", int'(b_out_ch), mch[1]);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    in_data = 32'h44332211;
    step(3);
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_data", int'(a_out_data), 0);
    chk("rst_ch", int'(a_out_ch), 0);
    chk("rst_ready", int'(a_in_ready), 0);
    rst = 1'b0;
    qch.delete();
    step(1);
    chk("first_ch", int'(a_out_ch), 0);
    chk("first_valid", int'(a_out_valid), 1);
    step(6);
    chk("rr_count", qch.size(), 6);
    for (int i = 0; i < 6 && i < qch.size(); i++) chk("rr_order", int'(qch[i]), i % 4);
    mode = 1'b0;
    sel = 2'd2;
    in_data = 32'h00A50000;
    #1;
    chk("fix_ready_pre", int'(a_in_ready), 4);
    step(1);
    chk("fix_data", int'(a_out_data), 8'hA5);
    chk("fix_ch", int'(a_out_ch), 2);
    chk("fix_ready", int'(a_in_ready), 4);
    mode = 1'b1;
    in_valid = 4'b1010;
    qch.delete();
    step(5);
    chk("alt_count", qch.size(), 5);
    for (int i = 0; i < 5 && i < qch.size(); i++) chk("alt_order", int'(qch[i]), (i == 0) ? 2 : ((i % 2) ? 3 : 1));
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'hf;
    in_data = 32'h0000003C;
    step(1);
    out_ready = 1'b0;
    in_data = 32'h00000011;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_data", int'(a_out_data), 8'h3C);
      chk("bp_ready", int'(a_in_ready), 0);
    end
    qd.delete();
    out_ready = 1'b1;
    step(1);
    chk("bp_accepts", qd.size(), 1);
    if (qd.size() > 0) chk("bp_word", int'(qd[0]), 8'h3C);
    chk("bp_next", int'(a_out_data), 8'h11);
    chk("bp_nobubble", int'(a_out_valid), 1);
    sel = 2'd3;
    step(1);
    chk("n3_valid", int'(b_out_valid), 0);
    chk("n3_ready", int'(b_in_ready), 0);
    mode = 1'b1;
    in_data = 32'h44332211;
    step(3);
    mode = 1'b0;
    sel = 2'd1;
    step(1);
    chk("sw_ch", int'(a_out_ch), 1);
    chk("sw_data", int'(a_out_data), 8'h22);
    repeat (400) begin
      rst = ($urandom_range(0, 39) == 0);
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_nto1_stream.md
# mux_nto1_stream

Parametrised, registered N-to-1 stream multiplexer; the sequential successor to our fixed 4:1 gate-level mux. It selects one of NCH WIDTH-bit input channels with valid/ready handshakes and forwards words through one output register. Selection is fixed (external select) or round-robin among requesting channels. It sits between multiple producers and a single shared consumer.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of input channels (≥2, need not be a power of two)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode; SELW = $clog2(NCH)
- in_data  in  NCH*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready; at most one bit high per cycle
- out_data  out  WIDTH  registered output word
- out_ch  out  SELW  source channel of out_data
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output

## Operation
- Output slot has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- slot_free = !out_valid || out_ready (combinational).
- Grant g each cycle:
  - fixed mode: g = sel. If sel ≥ NCH, no grant.
  - round-robin mode: first k with in_valid[k] high, searching cyclically from last_ch+1 up to last_ch. No grant if no in_valid bit is high.
- in_ready[k] = slot_free && grant valid && g == k && !rst. In fixed mode, in_ready[sel] does not depend on in_valid. In round-robin mode, ready may depend on valid; valid must never depend on ready.
- Transfer on channel k when in_valid[k] && in_ready[k]. At the clock edge:
  - out_data ← channel k word; out_ch ← k; out_valid ← 1.
  - last_ch ← k (both modes).
- slot_free with no transfer: out_valid ← 0. out_data and out_ch hold their last values.
- !slot_free: out_data, out_ch and out_valid hold; all in_ready bits are 0.
- Transitions:
  - EMPTY→FULL on a transfer.
  - FULL→FULL on a transfer while out_ready=1 (back-to-back), or while stalled.
  - FULL→EMPTY when out_ready=1 and there is no transfer.
- Mode and sel are sampled every cycle and take effect in the same cycle. last_ch is kept across mode changes.
- A word is never dropped or duplicated except by reset.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, last_ch=NCH-1 (so channel 0 has first round-robin priority), all in_ready=0 while rst=1.
- Reset mid-operation discards the held word. First grant is possible in the cycle after rst falls.
- Latency: input transfer at edge n → out_valid/out_data visible after edge n.
- Throughput: one word per cycle when out_ready stays 1.
- Round-robin fairness: with all NCH channels valid continuously and out_ready=1, the grant order is 0,1,…,NCH-1,0,…
- Backpressure: with out_ready=0 and a FULL slot, outputs stay stable until accepted.
- Simultaneous: out_ready=1 with a new transfer in the same cycle gives replacement with no bubble.

## Structure
- Package mux_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1
  - helper function for SELW derivation
- Sub-module mux_rr_pick: combinational rotating-priority picker.
  - parameter NCH
  - inputs req[NCH], last[SELW]
  - outputs gnt_idx[SELW], gnt_any
- Top level holds the output register, last_ch, and the handshake logic.

## Test plan
- Reset: assert rst for 3 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout. First output after release comes from channel 0 (round-robin mode).
- Fixed mode (NCH=4, WIDTH=8), sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1:
  - in_ready=4'b0100 every cycle
  - out_data=8'hA5, out_ch=2 one cycle later
- Round-robin, all four channels valid, out_ready=1 → out_ch sequence 0,1,2,3,0,1 with out_valid continuously 1.
- Round-robin, only channels 1 and 3 valid → alternating out_ch 1,3,1,3; channels 0 and 2 never granted.
- Backpressure: out_ready=0 for 5 cycles with the slot FULL (out_data=8'h3C) → output stable, in_ready=0. Release → 8'h3C accepted once, next word follows with no bubble.
- Edge cases:
  - NCH=3, fixed sel=3 → no grant, out_valid drops to 0 after the current word is accepted.
  - Switching mode from round-robin to fixed mid-stream resumes at sel with no loss.
